// File: rtl/vga_pkg.sv
// Shared VGA timing constants and frame-buffer geometry for the scan-out path.
package vga_pkg;

    localparam int unsigned H_VIS   = 640;
    localparam int unsigned H_FP    = 16;
    localparam int unsigned H_SYNC  = 96;
    localparam int unsigned H_BP    = 48;
    localparam int unsigned H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;

    localparam int unsigned V_VIS   = 480;
    localparam int unsigned V_FP    = 10;
    localparam int unsigned V_SYNC  = 2;
    localparam int unsigned V_BP    = 33;
    localparam int unsigned V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    localparam int unsigned FB_W    = 128;
    localparam int unsigned FB_H    = 96;
    localparam int unsigned SCALE   = 5;

    localparam int unsigned ADDR_W  = 14;
    localparam int unsigned COORD_W = ADDR_W / 2;
    localparam int unsigned CNT_W   = 10;

endpackage

// File: rtl/vga_timing_gen.sv
// Pixel-tick divider plus horizontal/vertical counters, raw syncs and blanking flags.
module vga_timing_gen #(
    parameter int unsigned PIX_DIV = 2,
    parameter int unsigned H_VIS   = vga_pkg::H_VIS,
    parameter int unsigned H_FP    = vga_pkg::H_FP,
    parameter int unsigned H_SYNC  = vga_pkg::H_SYNC,
    parameter int unsigned H_BP    = vga_pkg::H_BP,
    parameter int unsigned V_VIS   = vga_pkg::V_VIS,
    parameter int unsigned V_FP    = vga_pkg::V_FP,
    parameter int unsigned V_SYNC  = vga_pkg::V_SYNC,
    parameter int unsigned V_BP    = vga_pkg::V_BP
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic                       pix_en,
    output logic [vga_pkg::CNT_W-1:0]  h_cnt,
    output logic [vga_pkg::CNT_W-1:0]  v_cnt,
    output logic                       hsync_raw,
    output logic                       vsync_raw,
    output logic                       visible,
    output logic                       line_end,
    output logic                       frame_end
);
    import vga_pkg::*;

    localparam int unsigned DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

    localparam logic [CNT_W-1:0] H_VIS_C  = CNT_W'(H_VIS);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_VIS + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_VIS + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] V_VIS_C  = CNT_W'(V_VIS);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_VIS + V_FP + V_SYNC + V_BP - 1);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_VIS + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_VIS + V_FP + V_SYNC);

    logic [DIV_W-1:0] div_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Gated by reset so the first tick lands on the first cycle after release.
    assign pix_en = !reset && (div_cnt == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_en) begin
            if (line_end) begin
                h_cnt <= '0;
                v_cnt <= frame_end ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    assign line_end  = (h_cnt == H_LAST);
    assign frame_end = line_end && (v_cnt == V_LAST);
    assign hsync_raw = !((h_cnt >= HS_START) && (h_cnt < HS_END));
    assign vsync_raw = !((v_cnt >= VS_START) && (v_cnt < VS_END));
    assign visible   = (h_cnt < H_VIS_C) && (v_cnt < V_VIS_C);

endmodule

// File: rtl/vga_vram_reader.sv
// VRAM scan-out: 5x5 pixel replication address generator and 2-stage pin pipeline.
module vga_vram_reader #(
    parameter int unsigned PIX_DIV = 2,
    parameter int unsigned SCALE   = vga_pkg::SCALE,
    parameter int unsigned H_VIS   = vga_pkg::H_VIS,
    parameter int unsigned H_FP    = vga_pkg::H_FP,
    parameter int unsigned H_SYNC  = vga_pkg::H_SYNC,
    parameter int unsigned H_BP    = vga_pkg::H_BP,
    parameter int unsigned V_VIS   = vga_pkg::V_VIS,
    parameter int unsigned V_FP    = vga_pkg::V_FP,
    parameter int unsigned V_SYNC  = vga_pkg::V_SYNC,
    parameter int unsigned V_BP    = vga_pkg::V_BP
) (
    input  logic                        clk,
    input  logic                        reset,
    output logic [vga_pkg::ADDR_W-1:0]  vram_addr,
    output logic                        vram_en,
    input  logic                        vram_dout_r,
    input  logic                        vram_dout_g,
    input  logic                        vram_dout_b,
    output logic                        vga_hsync,
    output logic                        vga_vsync,
    output logic                        vga_r,
    output logic                        vga_g,
    output logic                        vga_b
);
    import vga_pkg::*;

    localparam int unsigned REP_W = (SCALE > 1) ? $clog2(SCALE) : 1;
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(SCALE - 1);
    localparam logic [CNT_W-1:0] H_VIS_C  = CNT_W'(H_VIS);
    localparam logic [CNT_W-1:0] V_VIS_C  = CNT_W'(V_VIS);

    logic               pix_en, hsync_raw, vsync_raw, visible, line_end, frame_end;
    logic [CNT_W-1:0]   h_cnt, v_cnt;
    logic [COORD_W-1:0] col, row;
    logic [REP_W-1:0]   col_rep, row_rep;
    logic               s1_hsync, s1_vsync, s1_vis;

    vga_timing_gen #(
        .PIX_DIV (PIX_DIV),
        .H_VIS   (H_VIS),
        .H_FP    (H_FP),
        .H_SYNC  (H_SYNC),
        .H_BP    (H_BP),
        .V_VIS   (V_VIS),
        .V_FP    (V_FP),
        .V_SYNC  (V_SYNC),
        .V_BP    (V_BP)
    ) u_timing (
        .clk       (clk),
        .reset     (reset),
        .pix_en    (pix_en),
        .h_cnt     (h_cnt),
        .v_cnt     (v_cnt),
        .hsync_raw (hsync_raw),
        .vsync_raw (vsync_raw),
        .visible   (visible),
        .line_end  (line_end),
        .frame_end (frame_end)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            col     <= '0;
            col_rep <= '0;
        end else if (pix_en) begin
            if (line_end) begin
                col     <= '0;
                col_rep <= '0;
            end else if (h_cnt < H_VIS_C) begin
                if (col_rep == REP_LAST) begin
                    col_rep <= '0;
                    col     <= col + 1'b1;
                end else begin
                    col_rep <= col_rep + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            row     <= '0;
            row_rep <= '0;
        end else if (pix_en && line_end) begin
            if (frame_end) begin
                row     <= '0;
                row_rep <= '0;
            end else if (v_cnt < V_VIS_C) begin
                if (row_rep == REP_LAST) begin
                    row_rep <= '0;
                    row     <= row + 1'b1;
                end else begin
                    row_rep <= row_rep + 1'b1;
                end
            end
        end
    end

    // Address loads only on visible ticks, so row/col overrun during blanking never reaches the port.
    always_ff @(posedge clk) begin
        if (reset) begin
            vram_addr <= '0;
            vram_en   <= 1'b0;
            s1_hsync  <= 1'b1;
            s1_vsync  <= 1'b1;
            s1_vis    <= 1'b0;
        end else if (pix_en) begin
            vram_en  <= visible;
            s1_hsync <= hsync_raw;
            s1_vsync <= vsync_raw;
            s1_vis   <= visible;
            if (visible) begin
                vram_addr <= {row, col};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vga_hsync <= 1'b1;
            vga_vsync <= 1'b1;
            vga_r     <= 1'b0;
            vga_g     <= 1'b0;
            vga_b     <= 1'b0;
        end else if (pix_en) begin
            vga_hsync <= s1_hsync;
            vga_vsync <= s1_vsync;
            vga_r     <= s1_vis & vram_dout_r;
            vga_g     <= s1_vis & vram_dout_g;
            vga_b     <= s1_vis & vram_dout_b;
        end
    end

endmodule

// File: tb/tb_vga_vram_reader.sv
// Bench for vga_vram_reader with a shortened vertical frame; model works from screen position arithmetic.
module tb_vga_vram_reader;

    localparam int H_TOT = 800;
    localparam int VV    = 20;
    localparam int V_TOT = 27;
    localparam int FRAME = H_TOT * V_TOT;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [13:0] vram_addr;
    logic        vram_en;
    logic        vram_dout_r = 1'b0, vram_dout_g = 1'b0, vram_dout_b = 1'b0;
    logic        vga_hsync, vga_vsync, vga_r, vga_g, vga_b;

    bit mem_r [0:16383];
    bit mem_g [0:16383];
    bit mem_b [0:16383];

    int n = 0;
    int tests = 0;
    int errors = 0;
    int held_addr = 0;

    vga_vram_reader #(
        .PIX_DIV (2),
        .V_VIS   (VV),
        .V_FP    (2),
        .V_SYNC  (2),
        .V_BP    (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .vram_addr   (vram_addr),
        .vram_en     (vram_en),
        .vram_dout_r (vram_dout_r),
        .vram_dout_g (vram_dout_g),
        .vram_dout_b (vram_dout_b),
        .vga_hsync   (vga_hsync),
        .vga_vsync   (vga_vsync),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b)
    );

    always #5 clk = ~clk;

    // Synchronous-read VRAM: data appears one clk after the address.
    always @(posedge clk) begin
        if (vram_en) begin
            vram_dout_r <= mem_r[vram_addr];
            vram_dout_g <= mem_g[vram_addr];
            vram_dout_b <= mem_b[vram_addr];
        end
    end

    // n = clk edges since the last edge that saw reset high.
    always @(posedge clk) begin
        if (reset) n <= 0;
        else       n <= n + 1;
    end

    function automatic bit is_vis(int p);
        return ((p % H_TOT) < 640) && ((p / H_TOT) < VV);
    endfunction

    function automatic int addr_of(int p);
        return ((p / H_TOT) / 5) * 128 + (p % H_TOT) / 5;
    endfunction

    task automatic check_cycle();
        int t, q, h, v;
        bit e_en, e_hs, e_vs, e_r, e_g, e_b;
        e_en = 0; e_hs = 1; e_vs = 1; e_r = 0; e_g = 0; e_b = 0;
        if (n == 0) begin
            held_addr = 0;
        end else begin
            t = ((n - 1) / 2) % FRAME;
            if ((n % 2) == 1 && is_vis(t)) held_addr = addr_of(t);
            e_en = is_vis(t);
            q = (n - 1) / 2 - 1;
            if (q >= 0) begin
                q = q % FRAME;
                h = q % H_TOT;
                v = q / H_TOT;
                e_hs = !(h >= 656 && h < 752);
                e_vs = !(v >= VV + 2 && v < VV + 4);
                if (is_vis(q)) begin
                    e_r = mem_r[addr_of(q)];
                    e_g = mem_g[addr_of(q)];
                    e_b = mem_b[addr_of(q)];
                end
            end
        end
        tests++;
        if (vram_en !== e_en || vram_addr !== 14'(held_addr)) begin
            errors++;
            $display("FAIL vram_port n=%0d got en=%0b addr=%0d expected en=%0b addr=%0d",
                     n, vram_en, vram_addr, e_en, held_addr);
        end
        tests++;
        if (vga_hsync !== e_hs || vga_vsync !== e_vs ||
            vga_r !== e_r || vga_g !== e_g || vga_b !== e_b) begin
            errors++;
            $display("FAIL pins n=%0d got hs=%0b vs=%0b rgb=%0b%0b%0b expected hs=%0b vs=%0b rgb=%0b%0b%0b",
                     n, vga_hsync, vga_vsync, vga_r, vga_g, vga_b, e_hs, e_vs, e_r, e_g, e_b);
        end
    endtask

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            check_cycle();
        end
    end

    task automatic lit(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s n=%0d got %0d expected %0d", name, n, got, exp);
        end
    endtask

    task automatic at_n(input int target);
        int guard;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (n != target && guard < 100000);
        if (n != target) begin
            tests++;
            errors++;
            $display("FAIL wait_n target=%0d got n=%0d", target, n);
        end
    endtask

    initial begin
        mem_r[257] = 1'b1;
        mem_g[0]   = 1'b1;
        mem_g[127] = 1'b1;
        mem_b[511] = 1'b1;

        repeat (5) @(posedge clk);
        @(negedge clk);
        lit("rst_hsync", int'(vga_hsync), 1);
        lit("rst_vsync", int'(vga_vsync), 1);
        lit("rst_rgb",   int'({vga_r, vga_g, vga_b}), 0);
        lit("rst_addr",  int'(vram_addr), 0);
        lit("rst_en",    int'(vram_en), 0);
        @(posedge clk); #2 reset = 1'b0;

        at_n(0);     lit("first_tick_en0", int'(vram_en), 0);
        at_n(1);     lit("first_tick_en1", int'(vram_en), 1);
        at_n(1314);  lit("hs_before", int'(vga_hsync), 1);
        at_n(1315);  lit("hs_fall",   int'(vga_hsync), 0);
        at_n(1506);  lit("hs_last",   int'(vga_hsync), 0);
        at_n(1507);  lit("hs_rise",   int'(vga_hsync), 1);
        at_n(2914);  lit("hs2_before", int'(vga_hsync), 1);
        at_n(2915);  lit("hs2_fall",  int'(vga_hsync), 0);
        at_n(16011); lit("addr_257",  int'(vram_addr), 257);
        at_n(16012); lit("r_x4",      int'(vga_r), 0);
        at_n(16013); lit("r_x5",      int'(vga_r), 1);
        at_n(16022); lit("r_x9",      int'(vga_r), 1);
        at_n(16023); lit("r_x10",     int'(vga_r), 0);
        at_n(22413); lit("r_y14",     int'(vga_r), 1);
        at_n(24013); lit("r_y15",     int'(vga_r), 0);
        at_n(31679); lit("last_addr", int'(vram_addr), 511);
        at_n(31681); lit("blank_en",  int'(vram_en), 0);
                     lit("blank_addr", int'(vram_addr), 511);
        at_n(35202); lit("vs_before", int'(vga_vsync), 1);
        at_n(35203); lit("vs_fall",   int'(vga_vsync), 0);
        at_n(38402); lit("vs_last",   int'(vga_vsync), 0);
        at_n(38403); lit("vs_rise",   int'(vga_vsync), 1);
        at_n(43201); lit("frame2_addr", int'(vram_addr), 0);
                     lit("frame2_en", int'(vram_en), 1);

        // Second frame, v=15 h=300: single-clock reset pulse.
        at_n(67800);
        @(posedge clk); #2 reset = 1'b1;
        @(posedge clk); #2 reset = 1'b0;
        at_n(0);
        lit("mid_rst_hsync", int'(vga_hsync), 1);
        lit("mid_rst_vsync", int'(vga_vsync), 1);
        lit("mid_rst_rgb",   int'({vga_r, vga_g, vga_b}), 0);
        lit("mid_rst_addr",  int'(vram_addr), 0);
        at_n(1);
        lit("mid_restart_addr", int'(vram_addr), 0);
        lit("mid_restart_en",   int'(vram_en), 1);
        at_n(3000);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
